// File: rtl/pattern_sequencer.sv
// pattern_sequencer: time-stepped IO exerciser. It drives N_OUT pins with a
// walking-one, bounce, binary-count or bar-fill pattern. A debounced button
// cycles the mode, and RUN gates the step prescaler.
module pattern_sequencer #(
  parameter int N_OUT         = 23,
  parameter int LOG2DELAY     = 20,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             BTN_N,
  input  logic             RUN,
  output logic [N_OUT-1:0] PINS,
  output logic [1:0]       MODE,
  output logic             STEP
);

  localparam int               PW        = $clog2(N_OUT);
  localparam logic [PW-1:0]    POS_LAST  = PW'(N_OUT - 1);
  localparam logic [PW-1:0]    POS_ONE   = PW'(1);
  localparam logic [N_OUT-1:0] PINS_INIT = N_OUT'(1);

  localparam logic [1:0] M_WALK   = 2'd0;
  localparam logic [1:0] M_BOUNCE = 2'd1;
  localparam logic [1:0] M_COUNT  = 2'd2;

  logic [LOG2DELAY-1:0]     pre_q;
  logic                     btn_s1, btn_s2, btn_stable;
  logic [DEBOUNCE_BITS-1:0] dcnt_q;
  logic [1:0]               mode_q;
  logic [PW-1:0]            pos_q, pos_n;
  logic                     dir_q, dir_n;       // 0 = up, 1 = down
  logic [N_OUT-1:0]         cnt_q, cnt_n;
  logic [N_OUT-1:0]         pins_q, pins_n;
  logic                     step_q;

  logic tick, btn_diff, btn_done, press;

  assign tick     = RUN & (&pre_q);
  assign btn_diff = btn_s2 != btn_stable;
  assign btn_done = btn_diff & (&dcnt_q);
  // Only the 1->0 edge of the debounced level is an event; release is silent.
  assign press    = btn_done & ~btn_s2;

  // Step prescaler. It runs freely through mode changes and freezes with RUN.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)  pre_q <= '0;
    else if (RUN)  pre_q <= pre_q + LOG2DELAY'(1);
  end

  // Button synchroniser and debounce. The level must differ for 2**DEBOUNCE_BITS evaluations.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      btn_s1     <= 1'b1;
      btn_s2     <= 1'b1;
      btn_stable <= 1'b1;
      dcnt_q     <= '0;
    end else begin
      btn_s1 <= BTN_N;
      btn_s2 <= btn_s1;
      if (btn_diff) begin
        if (btn_done) begin
          btn_stable <= btn_s2;
          dcnt_q     <= '0;
        end else begin
          dcnt_q <= dcnt_q + DEBOUNCE_BITS'(1);
        end
      end else begin
        dcnt_q <= '0;
      end
    end
  end

  // Pattern state register. A press restarts the pattern and wins over a coincident tick.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_q <= M_WALK;
      pos_q  <= '0;
      dir_q  <= 1'b0;
      cnt_q  <= '0;
      pins_q <= PINS_INIT;
      step_q <= 1'b0;
    end else if (press) begin
      mode_q <= mode_q + 2'd1;
      pos_q  <= '0;
      dir_q  <= 1'b0;
      cnt_q  <= '0;
      pins_q <= PINS_INIT;
      step_q <= 1'b0;
    end else if (tick) begin
      pos_q  <= pos_n;
      dir_q  <= dir_n;
      cnt_q  <= cnt_n;
      pins_q <= pins_n;
      step_q <= 1'b1;
    end else begin
      step_q <= 1'b0;
    end
  end

  // Next pattern step for the current mode. PINS always reflects the new position.
  always_comb begin
    pos_n  = pos_q;
    dir_n  = dir_q;
    cnt_n  = cnt_q;
    pins_n = pins_q;
    unique case (mode_q)
      M_WALK: begin
        pos_n  = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;
        pins_n = PINS_INIT << pos_n;
      end
      M_BOUNCE: begin
        if (!dir_q) begin
          if (pos_q == POS_LAST) begin
            dir_n = 1'b1;
            pos_n = POS_LAST - POS_ONE;
          end else begin
            pos_n = pos_q + POS_ONE;
          end
        end else begin
          if (pos_q == '0) begin
            dir_n = 1'b0;
            pos_n = POS_ONE;
          end else begin
            pos_n = pos_q - POS_ONE;
          end
        end
        pins_n = PINS_INIT << pos_n;
      end
      M_COUNT: begin
        cnt_n  = cnt_q + PINS_INIT;
        pins_n = cnt_n;
      end
      default: begin
        // FILL: use a 32-bit shift amount so that pos+1 == N_OUT gives all ones even at N_OUT=32.
        pos_n  = (pos_q == POS_LAST) ? '0 : pos_q + POS_ONE;
        pins_n = ~({N_OUT{1'b1}} << (32'(pos_n) + 32'd1));
      end
    endcase
  end

  // Outputs come straight from registers, so no combinational glitches reach the pins.
  always_comb begin
    PINS = pins_q;
    MODE = mode_q;
    STEP = step_q;
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Randomised bench for pattern_sequencer. The reference model tracks the
// prescaler phase, the steps taken since mode entry and the debounced button
// level. It derives the expected pins from closed-form pattern formulas.
module tb_pattern_sequencer;

  localparam int N   = 5;
  localparam int LD  = 2;
  localparam int DB  = 2;
  localparam int PER = 1 << LD;

  logic         CLK = 1'b0;
  logic         RESET_N, BTN_N, RUN;
  logic [N-1:0] PINS;
  logic [1:0]   MODE;
  logic         STEP;

  pattern_sequencer #(.N_OUT(N), .LOG2DELAY(LD), .DEBOUNCE_BITS(DB)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .BTN_N(BTN_N), .RUN(RUN),
    .PINS(PINS), .MODE(MODE), .STEP(STEP)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model state
  int           ph, mmode, k, dlen;
  bit           b1, b2, mstable;
  logic         estep;
  logic [N-1:0] epins;

  // The pattern after k steps in mode m. k == 0 is the reset/press value.
  function automatic logic [N-1:0] pat(int m, int kk);
    int p;
    if (kk == 0) return N'(1);
    case (m)
      0: return N'(1 << (kk % N));
      1: begin
        p = kk % (2 * (N - 1));
        if (p >= N) p = 2 * (N - 1) - p;
        return N'(1 << p);
      end
      2: return N'(kk % (1 << N));
      default: return N'((1 << ((kk % N) + 1)) - 1);
    endcase
  endfunction

  task automatic mreset();
    ph = 0; mmode = 0; k = 0; dlen = 0;
    b1 = 1'b1; b2 = 1'b1; mstable = 1'b1;
    estep = 1'b0; epins = N'(1);
  endtask

  // Advance one clock. The model takes the inputs seen at the edge, and outputs are then settled at edge+1.
  task automatic clk1();
    bit press, tick;
    @(posedge CLK);
    cyc++;
    if (!RESET_N) mreset();
    else begin
      press = 1'b0;
      if (b2 != mstable) begin
        dlen++;
        if (dlen == (1 << DB)) begin
          mstable = b2; dlen = 0; press = !b2;
        end
      end else dlen = 0;
      b2 = b1; b1 = BTN_N;
      tick = RUN && (ph == PER - 1);
      if (RUN) ph = (ph + 1) % PER;
      if (press) begin mmode = (mmode + 1) % 4; k = 0; estep = 1'b0; end
      else if (tick) begin k++; estep = 1'b1; end
      else estep = 1'b0;
      epins = pat(mmode, k);
    end
    #1;
  endtask

  task automatic press_btn(int lowlen);
    BTN_N = 1'b0;
    repeat (lowlen) clk1();
    BTN_N = 1'b1;
    repeat (8) clk1();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; BTN_N = 1'b1; RUN = 1'b0;
    mreset();
    repeat (3) clk1();
    n_tests++;
    if (PINS !== N'(1) || MODE !== 2'd0 || STEP !== 1'b0) begin
      n_fail++;
      $display("FAIL reset PINS=%b exp 00001 MODE=%0d exp 0 STEP=%b exp 0", PINS, MODE, STEP);
    end
    RESET_N = 1'b1;
  endtask

  task automatic test_walk();
    RUN = 1'b1;
    for (int i = 0; i < 26; i++) begin
      clk1();
      n_tests++;
      if (PINS !== epins || MODE !== 2'(mmode) || STEP !== estep) begin
        n_fail++;
        $display("FAIL walk cyc=%0d PINS=%b exp %b MODE=%0d exp %0d STEP=%b exp %b", cyc, PINS, epins, MODE, mmode, STEP, estep);
      end
    end
  endtask

  task automatic test_pause();
    for (int i = 0; i < 24; i++) begin
      RUN = !(i >= 2 && i < 12);
      clk1();
      n_tests++;
      if (PINS !== epins || STEP !== estep) begin
        n_fail++;
        $display("FAIL pause cyc=%0d PINS=%b exp %b STEP=%b exp %b", cyc, PINS, epins, STEP, estep);
      end
    end
    RUN = 1'b1;
  endtask

  task automatic test_debounce();
    for (int i = 0; i < 2 * 20; i++) begin
      // The first window is a 3-cycle glitch and the second a 10-cycle real press.
      BTN_N = !((i < 3) || (i >= 20 && i < 30));
      clk1();
      n_tests++;
      if (PINS !== epins || MODE !== 2'(mmode) || STEP !== estep) begin
        n_fail++;
        $display("FAIL debounce cyc=%0d PINS=%b exp %b MODE=%0d exp %0d STEP=%b exp %b", cyc, PINS, epins, MODE, mmode, STEP, estep);
      end
      if (i == 19) begin
        n_tests++;
        if (MODE !== 2'd0) begin
          n_fail++;
          $display("FAIL glitch_press MODE=%0d exp 0", MODE);
        end
      end
    end
    BTN_N = 1'b1;
    n_tests++;
    if (MODE !== 2'd1) begin
      n_fail++;
      $display("FAIL real_press MODE=%0d exp 1", MODE);
    end
  endtask

  task automatic test_pattern(int cycles, string name);
    for (int i = 0; i < cycles; i++) begin
      clk1();
      n_tests++;
      if (PINS !== epins || MODE !== 2'(mmode) || STEP !== estep) begin
        n_fail++;
        $display("FAIL %s cyc=%0d PINS=%b exp %b MODE=%0d exp %0d STEP=%b exp %b", name, cyc, PINS, epins, MODE, mmode, STEP, estep);
      end
    end
  endtask

  task automatic test_press_tick();
    int d, w, m0;
    // The press lands 2 sync edges plus 2**DB debounce edges after BTN falls, so it is aligned to a tick edge here.
    d  = PER - ph;
    w  = ((d - (2 + (1 << DB))) % PER + PER) % PER;
    m0 = mmode;
    repeat (w) clk1();
    BTN_N = 1'b0;
    for (int i = 0; i < 2 + (1 << DB); i++) begin
      clk1();
      n_tests++;
      if (PINS !== epins || MODE !== 2'(mmode) || STEP !== estep) begin
        n_fail++;
        $display("FAIL press_tick cyc=%0d PINS=%b exp %b MODE=%0d exp %0d STEP=%b exp %b", cyc, PINS, epins, MODE, mmode, STEP, estep);
      end
    end
    n_tests++;
    if (STEP !== 1'b0 || PINS !== N'(1) || MODE !== 2'((m0 + 1) % 4)) begin
      n_fail++;
      $display("FAIL press_wins STEP=%b exp 0 PINS=%b exp 00001 MODE=%0d exp %0d", STEP, PINS, MODE, (m0 + 1) % 4);
    end
    BTN_N = 1'b1;
    repeat (8) clk1();
    // Four more presses must bring the mode all the way around.
    for (int i = 1; i <= 4; i++) begin
      press_btn(6);
      n_tests++;
      if (MODE !== 2'((m0 + 1 + i) % 4)) begin
        n_fail++;
        $display("FAIL mode_cycle press=%0d MODE=%0d exp %0d", i, MODE, (m0 + 1 + i) % 4);
      end
    end
  endtask

  task automatic test_async_reset();
    int first;
    while (mmode != 2) press_btn(6);
    test_pattern(9, "pre_reset");
    for (int i = 0; i < PER && !estep; i++) clk1();
    // Assert reset between edges, with STEP high, and check that the outputs clear without any clock.
    RESET_N = 1'b0;
    #2;
    mreset();
    n_tests++;
    if (PINS !== N'(1) || MODE !== 2'd0 || STEP !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset PINS=%b exp 00001 MODE=%0d exp 0 STEP=%b exp 0", PINS, MODE, STEP);
    end
    #1 RESET_N = 1'b1;
    first = -1;
    for (int i = 1; i <= 8; i++) begin
      clk1();
      if (STEP === 1'b1 && first < 0) first = i;
    end
    n_tests++;
    if (first != PER) begin
      n_fail++;
      $display("FAIL first_step_after_reset cycles=%0d exp %0d", first, PER);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      RUN = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) BTN_N = ~BTN_N;
      clk1();
      n_tests++;
      if (PINS !== epins || MODE !== 2'(mmode) || STEP !== estep) begin
        n_fail++;
        $display("FAIL random cyc=%0d PINS=%b exp %b MODE=%0d exp %0d STEP=%b exp %b", cyc, PINS, epins, MODE, mmode, STEP, estep);
      end
    end
    BTN_N = 1'b1;
    RUN   = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_walk();
    test_pause();
    test_debounce();
    test_pattern(44, "bounce");
    press_btn(6);
    test_pattern(140, "count");
    press_btn(6);
    test_pattern(28, "fill");
    test_press_tick();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
